// File: rtl/seg_pkg.sv
// Shared definitions for the segment display scheduler.
//   state_t        : scheduler FSM states (idle, showing a source, alarm)
//   DEF_*          : default parameter values for the scheduler
//   idx_w()        : width of an index selecting one of n sources
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    localparam int DEF_N_SRC      = 4;
    localparam int DEF_DWELL      = 50_000_000;
    localparam int DEF_BLINK_HALF = 12_500_000;

    // A single source still needs a one-bit index so port widths stay legal.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   in  N_SRC  : request vector
//   ptr   in  IDX_W  : index of the last owner; search starts one above it
//   found out 1      : at least one request is present
//   idx   out IDX_W  : first requesting index found from ptr+1, wrapping
module rr_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk the candidates from the farthest (ptr itself) down to the nearest
    // (ptr+1) so the last hit written is the highest-priority one. ptr itself
    // is checked last, which lets a sole requester keep its grant.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            int cand;
            cand = (int'(ptr) + k) % N_SRC;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares a two-digit segment display between N_SRC requesters, with an
// alarm override that blinks an alarm code.
//   clk, rst_n  : clock and asynchronous active-low reset
//   req         : per-source level request
//   data        : packed source bytes, source i at [8i+7:8i]
//   alarm       : level alarm request, overrides everything
//   alarm_code  : byte shown during alarm
//   value       : byte to the segment decoder (registered)
//   blank       : display dark (registered)
//   grant       : one-hot current owner or zero (registered)
//   active_src  : index of the current/last owner (registered)
//   switch_p    : one-cycle pulse whenever grant changes (registered)
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int N_SRC      = DEF_N_SRC,
    parameter int DWELL      = DEF_DWELL,
    parameter int BLINK_HALF = DEF_BLINK_HALF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC-1:0]          req,
    input  logic [8*N_SRC-1:0]        data,
    input  logic                      alarm,
    input  logic [7:0]                alarm_code,
    output logic [7:0]                value,
    output logic                      blank,
    output logic [N_SRC-1:0]          grant,
    output logic [idx_w(N_SRC)-1:0]   active_src,
    output logic                      switch_p
);

    localparam int IDX_W   = idx_w(N_SRC);
    localparam int DWELL_W = $clog2(DWELL + 1);
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_HALF - 1);
    localparam logic [N_SRC-1:0]   ONE_HOT0   = N_SRC'(1);

    state_t             state_q, state_d;
    logic [7:0]         value_q, value_d;
    logic               blank_q, blank_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   active_src_q, active_src_d;
    logic               switch_p_q, switch_p_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [BLINK_W-1:0] blink_q, blink_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               rearb;

    rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and registered-output logic. Alarm preempts every state.
    // Idle, an expired dwell and a dropped owner all funnel into one
    // re-arbitration path: because the picker checks the current owner last,
    // a sole requester is simply re-granted and grant does not change.
    always_comb begin
        state_d      = state_q;
        value_d      = value_q;
        blank_d      = blank_q;
        grant_d      = grant_q;
        active_src_d = active_src_q;
        ptr_d        = ptr_q;
        dwell_d      = dwell_q;
        blink_d      = blink_q;
        rearb        = 1'b0;

        if (alarm && state_q != ST_ALARM) begin
            state_d = ST_ALARM;
            value_d = alarm_code;
            blank_d = 1'b0;
            grant_d = '0;
            dwell_d = '0;
            blink_d = BLINK_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: rearb = 1'b1;
                ST_SHOW: begin
                    if (!req[active_src_q] || dwell_q == '0) begin
                        rearb = 1'b1;
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                        value_d = data[8*active_src_q +: 8];
                    end
                end
                ST_ALARM: begin
                    if (alarm) begin
                        value_d = alarm_code;
                        if (blink_q == '0) begin
                            blank_d = ~blank_q;
                            blink_d = BLINK_LOAD;
                        end else begin
                            blink_d = blink_q - 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        value_d = 8'h00;
                        blank_d = 1'b1;
                        grant_d = '0;
                        blink_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (rearb) begin
            if (pick_found) begin
                state_d      = ST_SHOW;
                grant_d      = ONE_HOT0 << pick_idx;
                active_src_d = pick_idx;
                ptr_d        = pick_idx;
                dwell_d      = DWELL_LOAD;
                value_d      = data[8*pick_idx +: 8];
                blank_d      = 1'b0;
            end else begin
                state_d = ST_IDLE;
                value_d = 8'h00;
                blank_d = 1'b1;
                grant_d = '0;
                dwell_d = '0;
            end
        end

        switch_p_d = (grant_d != grant_q);
    end

    // State and output registers; ptr resets to the top index so the first
    // pick after reset starts at source 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            value_q      <= 8'h00;
            blank_q      <= 1'b1;
            grant_q      <= '0;
            active_src_q <= '0;
            switch_p_q   <= 1'b0;
            ptr_q        <= IDX_W'(N_SRC - 1);
            dwell_q      <= '0;
            blink_q      <= '0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            blank_q      <= blank_d;
            grant_q      <= grant_d;
            active_src_q <= active_src_d;
            switch_p_q   <= switch_p_d;
            ptr_q        <= ptr_d;
            dwell_q      <= dwell_d;
            blink_q      <= blink_d;
        end
    end

    assign value      = value_q;
    assign blank      = blank_q;
    assign grant      = grant_q;
    assign active_src = active_src_q;
    assign switch_p   = switch_p_q;

endmodule
